oled_seq: RTL and testbench

OLED_SEQ -- requirements
Module: oled_seq

---
 rtl/oled_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_oled_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_seq.sv
// oled_seq: power-up / init / frame sequencer for an SSD1306-style OLED that
// sits behind an I2C byte writer.
//
// After reset the block waits PWR_DLY cycles plus an idle writer. It then
// sends the fixed 31-byte init ROM as command bytes and raises init_done.
// From then on it serves user command bytes and streams whole frames of NPIX
// framebuffer bytes as data bytes.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   frame_go              one-cycle request to stream a full frame
//   pix_addr / pix_data   framebuffer read port; data valid 1 cycle after addr
//   cmd_valid / cmd_byte / cmd_ready   user command port
//   i2c_start / i2c_dcn / i2c_data     request to the byte writer (dcn 1=data)
//   i2c_busy              byte-writer busy flag
//   init_done             high once the init ROM has been sent, until rst
//   frame_busy / frame_done   frame in progress / 1-cycle pulse at frame end
//   dbg_fsm               {state, phase} for observation
//
// Handshake semantics
//   Command port: a byte transfers on a rising edge where cmd_valid and
//   cmd_ready are both 1. cmd_ready depends only on internal state, never on
//   cmd_valid. The producer holds cmd_byte stable while cmd_valid is high.
//   Writer port: i2c_start is held with i2c_data/i2c_dcn stable until
//   i2c_busy=1 is sampled. Start then drops, and data/dcn stay held until
//   i2c_busy=0 is sampled, which completes the byte.
module oled_seq #(
  parameter int PWR_DLY = 120000,
  parameter int NPIX    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_go,
  output logic [9:0] pix_addr,
  input  logic [7:0] pix_data,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic       i2c_start,
  output logic       i2c_dcn,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  output logic       init_done,
  output logic       frame_busy,
  output logic       frame_done,
  output logic [4:0] dbg_fsm
);

  typedef enum logic [2:0] {ST_PWRUP, ST_INIT, ST_READY, ST_CMD, ST_PIX} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_FETCH, PH_ISSUE, PH_WAIT} phase_t;

  localparam int PW = (PWR_DLY < 1) ? 1 : $clog2(PWR_DLY + 1);
  localparam logic [PW-1:0] PWR_MAX  = PW'(PWR_DLY);
  localparam logic [10:0]   LAST_PIX = 11'(NPIX - 1);
  localparam logic [4:0]    LAST_ROM = 5'd30;

  function automatic logic [7:0] rom_byte(input logic [4:0] i);
    case (i)
      5'd0:  rom_byte = 8'hAE;  5'd1:  rom_byte = 8'hD5;  5'd2:  rom_byte = 8'h80;
      5'd3:  rom_byte = 8'hA8;  5'd4:  rom_byte = 8'h3F;  5'd5:  rom_byte = 8'hD3;
      5'd6:  rom_byte = 8'h00;  5'd7:  rom_byte = 8'h40;  5'd8:  rom_byte = 8'h8D;
      5'd9:  rom_byte = 8'h14;  5'd10: rom_byte = 8'h20;  5'd11: rom_byte = 8'h00;
      5'd12: rom_byte = 8'hA1;  5'd13: rom_byte = 8'hC8;  5'd14: rom_byte = 8'hDA;
      5'd15: rom_byte = 8'h12;  5'd16: rom_byte = 8'h81;  5'd17: rom_byte = 8'hCF;
      5'd18: rom_byte = 8'hD9;  5'd19: rom_byte = 8'hF1;  5'd20: rom_byte = 8'hDB;
      5'd21: rom_byte = 8'h40;  5'd22: rom_byte = 8'hA4;  5'd23: rom_byte = 8'hA6;
      5'd24: rom_byte = 8'h21;  5'd25: rom_byte = 8'h00;  5'd26: rom_byte = 8'h7F;
      5'd27: rom_byte = 8'h22;  5'd28: rom_byte = 8'h00;  5'd29: rom_byte = 8'h07;
      5'd30: rom_byte = 8'hAF;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [PW-1:0]   pwr_cnt_q;
  logic [4:0]      rom_idx_q;
  logic [10:0]     byte_cnt_q;
  logic [9:0]      pix_addr_q;
  logic [7:0]      data_q, cmd_buf_q;
  logic            dcn_q, ret_pix_q, go_pend_q;
  logic            init_done_q, frame_busy_q, frame_done_q;

  // Per-cycle action strobes from the decoder, consumed by the datapath.
  logic       xfer_state, byte_done, accept, start_frame, frame_end;
  logic       pix_next, rom_next, set_init, data_ld, dcn_val;
  logic [7:0] data_val;

  assign xfer_state = (state_q == ST_INIT) || (state_q == ST_CMD) || (state_q == ST_PIX);
  assign byte_done  = xfer_state && (phase_q == PH_WAIT) && !i2c_busy;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cmd_ready   = 1'b0;
    accept      = 1'b0;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    pix_next    = 1'b0;
    rom_next    = 1'b0;
    set_init    = 1'b0;
    data_ld     = 1'b0;
    data_val    = 8'h00;
    dcn_val     = 1'b0;

    // ISSUE/WAIT behave identically for every byte type.
    if (xfer_state) begin
      if (phase_q == PH_ISSUE && i2c_busy) phase_d = PH_WAIT;
    end

    case (state_q)
      ST_PWRUP: begin
        if (pwr_cnt_q == PWR_MAX && !i2c_busy) begin
          state_d = ST_INIT;
          phase_d = PH_LOAD;
        end
      end
      ST_INIT: begin
        if (phase_q == PH_LOAD) begin
          data_ld  = 1'b1;
          data_val = rom_byte(rom_idx_q);
          phase_d  = PH_ISSUE;
        end else if (phase_q == PH_FETCH) begin
          phase_d = PH_LOAD;
        end else if (byte_done) begin
          phase_d = PH_LOAD;
          if (rom_idx_q == LAST_ROM) begin
            set_init = 1'b1;
            state_d  = ST_READY;
          end else begin
            rom_next = 1'b1;
          end
        end
      end
      ST_READY: begin
        cmd_ready = 1'b1;
        // A command wins over a pending or simultaneous frame request.
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_CMD;
          phase_d = PH_LOAD;
        end else if (frame_go || go_pend_q) begin
          start_frame = 1'b1;
          state_d     = ST_PIX;
          phase_d     = PH_LOAD;
        end
      end
      ST_CMD: begin
        if (phase_q == PH_LOAD || phase_q == PH_FETCH) begin
          data_ld  = 1'b1;
          data_val = cmd_buf_q;
          phase_d  = PH_ISSUE;
        end else if (byte_done) begin
          // Back into a frame we resume at FETCH, so the same boundary
          // cannot accept a second command.
          state_d = ret_pix_q ? ST_PIX : ST_READY;
          phase_d = ret_pix_q ? PH_FETCH : PH_LOAD;
        end
      end
      ST_PIX: begin
        if (phase_q == PH_LOAD) begin
          cmd_ready = init_done_q;
          if (cmd_valid && init_done_q) begin
            accept  = 1'b1;
            state_d = ST_CMD;
          end else begin
            phase_d = PH_FETCH;
          end
        end else if (phase_q == PH_FETCH) begin
          // pix_addr has been stable for at least one cycle here.
          data_ld  = 1'b1;
          data_val = pix_data;
          dcn_val  = 1'b1;
          phase_d  = PH_ISSUE;
        end else if (byte_done) begin
          phase_d = PH_LOAD;
          if (byte_cnt_q == LAST_PIX) begin
            frame_end = 1'b1;
            state_d   = ST_READY;
          end else begin
            pix_next = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_PWRUP;
        phase_d = PH_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PWRUP;
      phase_q <= PH_LOAD;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_cnt_q    <= '0;
      rom_idx_q    <= '0;
      byte_cnt_q   <= '0;
      pix_addr_q   <= '0;
      data_q       <= '0;
      dcn_q        <= 1'b0;
      cmd_buf_q    <= '0;
      ret_pix_q    <= 1'b0;
      go_pend_q    <= 1'b0;
      init_done_q  <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (state_q == ST_PWRUP && pwr_cnt_q != PWR_MAX) pwr_cnt_q <= pwr_cnt_q + PW'(1);
      if (rom_next) rom_idx_q <= rom_idx_q + 5'd1;
      if (data_ld) begin
        data_q <= data_val;
        dcn_q  <= dcn_val;
      end
      if (accept) begin
        cmd_buf_q <= cmd_byte;
        ret_pix_q <= (state_q == ST_PIX);
      end
      if (set_init) init_done_q <= 1'b1;
      // Requests outside a frame are remembered; requests during a frame are dropped.
      if (start_frame)                  go_pend_q <= 1'b0;
      else if (frame_go && !frame_busy_q) go_pend_q <= 1'b1;
      if (start_frame) begin
        frame_busy_q <= 1'b1;
        byte_cnt_q   <= '0;
        pix_addr_q   <= '0;
      end else if (frame_end) begin
        frame_busy_q <= 1'b0;
        byte_cnt_q   <= '0;
        pix_addr_q   <= '0;
      end else if (pix_next) begin
        byte_cnt_q   <= byte_cnt_q + 11'd1;
        pix_addr_q   <= pix_addr_q + 10'd1;
      end
      frame_done_q <= frame_end;
    end
  end

  assign i2c_start  = xfer_state && (phase_q == PH_ISSUE);
  assign i2c_data   = data_q;
  assign i2c_dcn    = dcn_q;
  assign pix_addr   = pix_addr_q;
  assign init_done  = init_done_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign dbg_fsm    = {state_q, phase_q};

endmodule

// File: tb/tb_oled_seq.sv
// Bench for oled_seq: small-parameter instance (PWR_DLY=16, NPIX=8), a
// randomized busy-model byte writer, a synchronous framebuffer model and an
// expected byte stream built from the ROM / frame / command ordering rules.
module tb_oled_seq;
  localparam int PWR = 16;
  localparam int NP  = 8;

  logic       clk, rst, frame_go, cmd_valid, cmd_ready;
  logic [9:0] pix_addr;
  logic [7:0] pix_data, cmd_byte, i2c_data;
  logic       i2c_start, i2c_dcn, i2c_busy, init_done, frame_busy, frame_done;
  logic [4:0] dbg_fsm;

  oled_seq #(.PWR_DLY(PWR), .NPIX(NP)) dut (
    .clk(clk), .rst(rst), .frame_go(frame_go), .pix_addr(pix_addr),
    .pix_data(pix_data), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .cmd_ready(cmd_ready), .i2c_start(i2c_start), .i2c_dcn(i2c_dcn),
    .i2c_data(i2c_data), .i2c_busy(i2c_busy), .init_done(init_done),
    .frame_busy(frame_busy), .frame_done(frame_done), .dbg_fsm(dbg_fsm)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] ram [NP];
  logic [7:0] rom_tbl [31];
  logic       hold_busy = 1'b0;
  int fd_cnt = 0, acc_cnt = 0, early_ready = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Framebuffer: registered read, data one cycle after address.
  always @(posedge clk) pix_data <= ram[pix_addr[2:0]];

  // Monitors (sampled on the falling edge, away from the active edge).
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (cmd_valid && cmd_ready) acc_cnt++;
    if (cmd_ready && !init_done && !rst) early_ready++;
  end

  // Busy-model byte writer: captures each requested byte, answers after a
  // random 0..3 cycle delay (start must stay up meanwhile), stays busy 2..4+.
  initial begin : writer
    int d, h;
    i2c_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_start && !i2c_busy && !rst) begin
        obs_q.push_back({i2c_dcn, i2c_data});
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          chk("start_hold", i2c_start, 1);
        end
        i2c_busy = 1'b1;
        h = $urandom_range(2, 4);
        repeat (h) @(negedge clk);
        while (hold_busy) @(negedge clk);
        i2c_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic go_pulse();
    @(posedge clk); #1 frame_go = 1'b1;
    @(posedge clk); #1 frame_go = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_byte = b;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 5000);
    chk("cmd_accept_timeout", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_size(input int s);
    int n;
    n = 0;
    while (obs_q.size() < s && n < 5000) begin @(negedge clk); n++; end
    chk("size_timeout", obs_q.size() >= s, 1);
  endtask

  task automatic wait_quiet(input int n_exp);
    int n;
    n = 0;
    while (!(obs_q.size() >= n_exp && !frame_busy && !i2c_start && !i2c_busy) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("quiet_timeout", n < 5000, 1);
    repeat (40) @(negedge clk);
  endtask

  // ---------------- reference model / scoreboard ----------------
  task automatic exp_rom();
    for (int i = 0; i < 31; i++) exp_q.push_back({1'b0, rom_tbl[i]});
  endtask

  // Frame bytes with an optional command inserted after pixel k (k<0: before).
  task automatic exp_frame(input bit with_cmd, input int k, input logic [7:0] c);
    if (with_cmd && k < 0) exp_q.push_back({1'b0, c});
    for (int i = 0; i < NP; i++) begin
      exp_q.push_back({1'b1, ram[i]});
      if (with_cmd && i == k) exp_q.push_back({1'b0, c});
    end
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n, fd0, acc0, k, mode;
    logic [7:0] c;
    rom_tbl = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07,
                8'hAF};
    for (int i = 0; i < NP; i++) ram[i] = 8'(i);
    rst = 1'b1; frame_go = 1'b0; cmd_valid = 1'b0; cmd_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", i2c_start, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_busy", frame_busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_pix_addr", pix_addr, 0);
    chk("rst_data", {i2c_dcn, i2c_data}, 0);

    // Power-up delay, INIT ROM, frame request latched during INIT, a command
    // held off until init_done and served before that frame, and a
    // mid-frame frame_go that must be dropped.
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!i2c_start && n < 500);
    chk("pwrup_wait_ge_dly", n > PWR, 1);
    fd0 = fd_cnt; acc0 = acc_cnt;
    go_pulse();
    send_cmd(8'h3C);
    wait_size(31 + 1 + 3);
    chk("frame_busy_mid", frame_busy, 1);
    go_pulse();
    wait_quiet(31 + 1 + NP);
    exp_rom();
    exp_frame(1'b1, -1, 8'h3C);
    check_stream("init_frame");
    chk("init_done", init_done, 1);
    chk("early_ready", early_ready, 0);
    chk("frame_done_once", fd_cnt - fd0, 1);
    chk("cmd_accept_once", acc_cnt - acc0, 1);
    chk("pix_addr_wrap", pix_addr, 0);

    // Fixed insertion of A7 after pixel 3.
    fd0 = fd_cnt; acc0 = acc_cnt;
    go_pulse();
    wait_size(4);
    send_cmd(8'hA7);
    wait_quiet(NP + 1);
    exp_frame(1'b1, 3, 8'hA7);
    check_stream("cmd_after_p3");
    chk("a7_accept_once", acc_cnt - acc0, 1);
    chk("a7_frame_done", fd_cnt - fd0, 1);

    // Randomized frames: plain, mid-frame command, simultaneous go+command.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NP; i++) ram[i] = 8'($urandom);
      mode = $urandom_range(0, 2);
      k    = $urandom_range(0, NP - 2);
      c    = 8'($urandom);
      fd0 = fd_cnt; acc0 = acc_cnt;
      if (mode == 0) begin
        go_pulse();
        wait_quiet(NP);
        exp_frame(1'b0, 0, c);
      end else if (mode == 1) begin
        go_pulse();
        wait_size(k + 1);
        send_cmd(c);
        wait_quiet(NP + 1);
        exp_frame(1'b1, k, c);
      end else begin
        @(posedge clk); #1 frame_go = 1'b1; cmd_valid = 1'b1; cmd_byte = c;
        @(posedge clk); #1 frame_go = 1'b0; cmd_valid = 1'b0;
        wait_quiet(NP + 1);
        exp_frame(1'b1, -1, c);
      end
      check_stream("rand_frame");
      chk("rand_frame_done", fd_cnt - fd0, 1);
      chk("rand_accepts", acc_cnt - acc0, (mode == 0) ? 0 : 1);
      chk("rand_pix_addr", pix_addr, 0);
    end

    // Reset mid-pixel while the writer is busy.
    for (int i = 0; i < NP; i++) ram[i] = 8'($urandom);
    go_pulse();
    n = 0;
    while (!(frame_busy && i2c_busy && obs_q.size() >= 3) && n < 2000) begin @(negedge clk); n++; end
    chk("busy_in_pix", frame_busy && i2c_busy, 1);
    hold_busy = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_start", i2c_start, 0);
    chk("arst_data", {i2c_dcn, i2c_data}, 0);
    chk("arst_pix_addr", pix_addr, 0);
    chk("arst_cmd_ready", cmd_ready, 0);
    chk("arst_init_done", init_done, 0);
    chk("arst_frame_busy", {frame_busy, frame_done}, 0);
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (i2c_start) n++; end
    chk("no_start_while_busy", n, 0);
    hold_busy = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!i2c_start && n < 200);
    chk("restart_seen", i2c_start, 1);
    wait_quiet(31);
    exp_rom();
    check_stream("reinit");
    chk("reinit_done", init_done, 1);

    // Normal frame after recovery.
    fd0 = fd_cnt;
    for (int i = 0; i < NP; i++) ram[i] = 8'($urandom);
    go_pulse();
    wait_quiet(NP);
    exp_frame(1'b0, 0, 8'h00);
    check_stream("post_reset_frame");
    chk("post_reset_done", fd_cnt - fd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
